// File: rtl/comparator_rr_scheduler.sv
// Round-robin scheduler sharing one unsigned magnitude comparator.
// Ports: clk, rst, req, a_bus, b_bus -> grant, busy, done, done_id, EQ, G, L.
module comparator_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_bus,
  input  logic [N_REQ*WIDTH-1:0] b_bus,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic                   EQ,
  output logic                   G,
  output logic                   L
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   win_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              found;
  int                idx;

  // First requester at or after ptr, wrapping once around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      win_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      EQ      <= 1'b0;
      G       <= 1'b0;
      L       <= 1'b0;
    end else begin
      grant <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            a_q   <= a_bus[int'(win)*WIDTH +: WIDTH];
            b_q   <= b_bus[int'(win)*WIDTH +: WIDTH];
            win_q <= win;
            grant <= N_REQ'(1) << win;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          EQ      <= (a_q == b_q);
          G       <= (a_q >  b_q);
          L       <= (a_q <  b_q);
          done_id <= win_q;
          done    <= 1'b1;
          // Just-served requester drops to lowest priority.
          if (int'(win_q) == N_REQ-1) ptr <= '0;
          else                         ptr <= win_q + 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_rr_scheduler.sv
// Directed bench for comparator_rr_scheduler.
// Steps one clock at a time and checks outputs 1ns after each edge.
module tb_comparator_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic [3:0]  grant;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic        EQ;
  logic        G;
  logic        L;

  int tests = 0;
  int fails = 0;

  comparator_rr_scheduler #(
    .N_REQ(4), .WIDTH(4), .ID_W(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .a_bus(a_bus), .b_bus(b_bus),
    .grant(grant), .busy(busy), .done(done),
    .done_id(done_id), .EQ(EQ), .G(G), .L(L)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ab(input int i,
                        input logic [3:0] a,
                        input logic [3:0] b);
    a_bus[i*4 +: 4] = a;
    b_bus[i*4 +: 4] = b;
  endtask

  // {grant, busy, done, done_id, EQ, G, L}
  function automatic logic [31:0] pack_out();
    return {21'd0, grant, busy, done, done_id, EQ, G, L};
  endfunction

  initial begin
    logic [3:0] exp_g4 [5];
    logic [1:0] exp_id4 [5];
    rst = 1'b1; req = '0; a_bus = '0; b_bus = '0;
    exp_g4  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id4 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    step(); step();
    chk("reset_outputs", pack_out(), 32'd0);

    // 1: A0=9 > B0=3
    rst = 1'b0; req = 4'b0001; set_ab(0, 4'd9, 4'd3);
    step();
    chk("t1_grant", {grant, busy}, {4'b0001, 1'b1});
    req = 4'b0000;
    step();
    chk("t1_done", {grant, busy, done, done_id, EQ, G, L},
        {4'b0000, 1'b0, 1'b1, 2'd0, 3'b010});

    // 2: A2=7 == B2=7, result holds after done
    req = 4'b0100; set_ab(2, 4'd7, 4'd7);
    step();
    chk("t2_grant", grant, 4'b0100);
    req = 4'b0000;
    step();
    chk("t2_done", {done, done_id, EQ, G, L}, {1'b1, 2'd2, 3'b100});
    step(); step();
    chk("t2_hold", {done, busy, done_id, EQ, G, L},
        {1'b0, 1'b0, 2'd2, 3'b100});

    // 3: boundaries, operands changed in grant cycle are ignored
    req = 4'b0010; set_ab(1, 4'd0, 4'd15);
    step();
    chk("t3_grant1", grant, 4'b0010);
    req = 4'b0000; set_ab(1, 4'd15, 4'd0);
    step();
    chk("t3_lt", {done, done_id, EQ, G, L}, {1'b1, 2'd1, 3'b001});
    req = 4'b1000; set_ab(3, 4'd15, 4'd0);
    step();
    chk("t3_grant3", grant, 4'b1000);
    req = 4'b0000;
    step();
    chk("t3_gt", {done, done_id, EQ, G, L}, {1'b1, 2'd3, 3'b010});

    // 4: all requesting from reset -> rotation 0,1,2,3,0
    rst = 1'b1; req = 4'b1111;
    for (int i = 0; i < 4; i++) set_ab(i, 4'(i), 4'd2);
    step();
    chk("t4_reset", pack_out(), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t4_grant%0d", i), grant, exp_g4[i]);
      step();
      chk($sformatf("t4_done%0d", i), {grant, done, done_id},
          {4'b0000, 1'b1, exp_id4[i]});
    end

    // 5: req 0 and 2 held -> alternate 0,2,0,2
    rst = 1'b1; req = 4'b0101;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t5_grant%0d", i), grant,
          (i % 2 == 0) ? 4'b0001 : 4'b0100);
      step();
      chk($sformatf("t5_id%0d", i), {done, done_id},
          {1'b1, (i % 2 == 0) ? 2'd0 : 2'd2});
    end

    // 6: reset in BUSY discards compare; pointer back to 0
    rst = 1'b1; req = 4'b1010;
    set_ab(1, 4'd5, 4'd1); set_ab(3, 4'd1, 4'd5);
    step();
    rst = 1'b0;
    step();
    chk("t6_grant_first", grant, 4'b0010);
    rst = 1'b1;
    step();
    chk("t6_no_done", pack_out(), 32'd0);
    rst = 1'b0;
    step();
    chk("t6_regrant", grant, 4'b0010);
    step();
    chk("t6_done", {done, done_id, EQ, G, L}, {1'b1, 2'd1, 3'b010});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
